isqrt_seq_ctrl: RTL
===================

// Module: isqrt_seq_ctrl
// PURPOSE
// Sequential controller for the integer square root finder. Accepts an operand on a
// start/ready handshake and computes floor(sqrt) with the restoring digit-by-digit
// method, one root bit per clock. It holds root and remainder for the display path.
// {4'b0, root} drives bin of the existing 8-bit binary-to-BCD converter, so
// WIDTH=8 keeps the root in 0..15, the range that converter decodes.
// PARAMETERS
// WIDTH     8   operand width; even, >=2; root width RW=WIDTH/2 (localparam)
// PORTS
// clk        in   1        rising-edge clock
// reset      in   1        synchronous, active-high reset
// start      in   1        request; sampled only when ready=1
// operand    in   WIDTH    radicand; captured on the accepting edge
// ready      out  1        1 in IDLE only
// busy       out  1        1 in CALC only
// done       out  1        1-cycle pulse in DONE; results valid from this cycle
// root       out  RW       floor(sqrt(operand)); held until next completion
// remainder  out  RW+1     operand - root*root (max 2*root); held
// exact      out  1        1 when remainder==0; held with root
// BEHAVIOUR
// - Reset: all outputs 0 except ready=1; state IDLE; iteration count 0.
// - Reset has priority over every other event; reset during CALC aborts the
//   operation, clears root/remainder/exact, and produces no done pulse.
// - FSM: IDLE -(start)-> CALC -(last iteration)-> DONE -> IDLE (unconditional).
// - IDLE: start=1 at edge N latches operand into a shift reg; clears work regs
//   rem_w (RW+2 bits) and root_w (RW bits); sets iter=RW-1; goes to CALC.
// - CALC: one iteration per edge, RW edges total (N+1..N+RW):
//     rem_t = {rem_w, next 2 operand MSBs}; trial = {root_w, 2'b01}
//     rem_t >= trial: rem_w = rem_t - trial, root_w = {root_w,1}
//     otherwise:     rem_w = rem_t,         root_w = {root_w,0}
//   The comparison and subtraction use RW+2 bits; no overflow is possible.
//   At edge N+RW, root/remainder/exact load from the work regs; state -> DONE.
// - DONE: done=1 for exactly the cycle after edge N+RW. The next edge returns to IDLE.
// - Latency: start accepted at edge N -> done high in cycle [N+RW, N+RW+1).
//   The minimum accept-to-accept spacing is RW+2 edges (6 for WIDTH=8).
// - start while busy or in DONE: ignored, not queued. operand changes after the
//   accepting edge have no effect.
// - root/remainder/exact change only at the completing edge or on reset. There are
//   no glitches to the converter between completions.
// TESTING
// 1. operand=0, start 1 cycle -> done at cycle N+4; root=0, rem=0, exact=1.
// 2. operand=255 -> root=15, remainder=30, exact=0; converter upper=1, lower=5.
// 3. operand=144 -> root=12, rem=0, exact=1. operand=143 -> root=11, rem=22, exact=0.
// 4. Hold start high continuously with operands 16 then 17 -> accepts at edges
//    0 and 6 only; done pulses at 4 and 10; results 4/0 then 4/1.
// 5. Start operand=200, assert reset at edge N+2 -> no done; outputs 0; ready=1
//    next cycle. A new start with 81 -> root=9, rem=0.
// 6. Exhaustive 0..255, back-to-back -> root*root+rem==operand, rem<=2*root, and
//    ready/busy/done are one-hot with state every cycle.

Source files
------------

// File: rtl/isqrt_seq_ctrl.sv
// ---------------------------------------------------------------------------
// isqrt_seq_ctrl
// Sequential integer square root controller. It accepts an operand on a
// start/ready handshake and computes floor(sqrt(operand)) with the restoring
// digit-by-digit method, producing one root bit per clock. Root, remainder and
// exact flag are held between completions so that the downstream display path
// (binary-to-BCD converter fed with {4'b0, root}) sees a stable value.
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high reset
//   start      in   1          request, sampled only while ready=1
//   operand    in   WIDTH      radicand, captured on the accepting edge
//   ready      out  1          high in IDLE only
//   busy       out  1          high in CALC only
//   done       out  1          one-cycle pulse in DONE; results valid from here
//   root       out  WIDTH/2    floor(sqrt(operand)), held until next completion
//   remainder  out  WIDTH/2+1  operand - root*root, held
//   exact      out  1          remainder == 0, held with root
// ---------------------------------------------------------------------------
module isqrt_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     operand,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH/2-1:0]   root,
   output logic [WIDTH/2:0]     remainder,
   output logic                 exact
);

   localparam int RW = WIDTH / 2;
   // Iteration counter width; a single-bit counter still works for RW=1.
   localparam int IW = (RW > 1) ? $clog2(RW) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   logic [WIDTH-1:0]  r_shift;     // operand, consumed two MSBs per iteration
   logic [RW+1:0]     r_rem_w;     // partial remainder
   logic [RW-1:0]     r_root_w;    // partial root
   logic [IW-1:0]     r_iter;
   logic [RW-1:0]     r_root;
   logic [RW:0]       r_rem;
   logic              r_exact;

   logic [RW+1:0]     w_rem_t;
   logic [RW+1:0]     w_trial;
   logic              w_ge;
   logic [RW+1:0]     w_rem_next;
   logic [RW-1:0]     w_root_next;
   logic              w_last;

   // One restoring step. Before any step the partial remainder fits in RW
   // bits, so shifting it left by two into an RW+2 bit field loses nothing.
   always_comb begin
      w_rem_t     = (r_rem_w << 2) | {{RW{1'b0}}, r_shift[WIDTH-1 -: 2]};
      w_trial     = {r_root_w, 2'b01};
      w_ge        = (w_rem_t >= w_trial);
      w_rem_next  = w_ge ? (w_rem_t - w_trial) : w_rem_t;
      w_root_next = (r_root_w << 1) | {{(RW-1){1'b0}}, w_ge};
      w_last      = (r_iter == '0);
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and handshake outputs
   always_comb begin
      w_state_next = r_state;
      ready        = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            ready = 1'b1;
            if (start) begin
               w_state_next = S_CALC;
            end
         end
         S_CALC: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: work registers and held results
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift  <= '0;
         r_rem_w  <= '0;
         r_root_w <= '0;
         r_iter   <= '0;
         r_root   <= '0;
         r_rem    <= '0;
         r_exact  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift  <= operand;
                  r_rem_w  <= '0;
                  r_root_w <= '0;
                  r_iter   <= IW'(RW - 1);
               end
            end
            S_CALC: begin
               r_shift  <= r_shift << 2;
               r_rem_w  <= w_rem_next;
               r_root_w <= w_root_next;
               if (w_last) begin
                  // Results take the value of the final step directly so they
                  // are valid in the same cycle the done pulse appears.
                  r_root  <= w_root_next;
                  r_rem   <= w_rem_next[RW:0];
                  r_exact <= (w_rem_next == '0);
               end else begin
                  r_iter <= r_iter - 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign root      = r_root;
   assign remainder = r_rem;
   assign exact     = r_exact;

endmodule
